// File: rtl/i2s_apb_streamer.sv
// i2s_apb_streamer: buffers PCM samples in a small FIFO and feeds them to the
// I2S transceiver over its APB slave port. Before each write it polls the
// status register until the Tx-ready bit is set.
// Optional feature macro: I2S_STREAM_TIMEOUT_EN adds a poll limit. On reaching
// the limit it drops the head sample and raises a sticky timeout flag.
// POLL_GAP is expected to be >= 1.
`timescale 1ns/1ps
module i2s_apb_streamer #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] ADR_OFFSET = 32'h0,
    parameter logic [31:0] TXD_OFS    = 32'h4,
    parameter logic [31:0] STAT_OFS   = 32'h8,
    parameter int          TXRDY_BIT  = 12,
    parameter int          POLL_GAP   = 2,
    parameter int          MAX_POLLS  = 255
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        enable,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic [31:0] paddr,
    output logic        pwrite,
    output logic        penable,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    output logic        busy,
    output logic [15:0] sent_cnt,
    output logic        timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD_ACCESS, GAP, WR_SETUP, WR_ACCESS
    } state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop, drop, rdy_q;
    logic [GW-1:0] gap_cnt;
    logic          unused_prdata;

    // Only the Tx-ready bit of the status word matters.
    assign unused_prdata = ^prdata;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign s_ready = rdy_q & ~full;
    assign push    = s_valid & s_ready;
    assign busy    = ~empty | (state != IDLE);

`ifdef I2S_STREAM_TIMEOUT_EN
    localparam int PW = $clog2(MAX_POLLS + 1);
    logic [PW-1:0] poll_cnt;
    logic          timeout_q;
    assign timeout = timeout_q;

    // Drop the head sample when this failed poll is the last one allowed.
    always_comb begin
        drop = 1'b0;
        if (state == RD_ACCESS && !prdata[TXRDY_BIT] && poll_cnt == PW'(MAX_POLLS - 1))
            drop = 1'b1;
    end
`else
    localparam int UNUSED_MAX_POLLS = MAX_POLLS;
    assign timeout = 1'b0;
    assign drop    = 1'b0;
`endif

    // The head leaves the FIFO on a completed write, or when it is dropped after a timeout.
    always_comb begin
        pop = 1'b0;
        if (state == WR_ACCESS || drop)
            pop = 1'b1;
    end

    // Sample storage. It needs no reset because the pointers decide validity.
    always_ff @(posedge pclk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= s_data;
    end

    // FIFO pointers and the ready-after-reset flag.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Poll/write sequencer with registered APB outputs.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state    <= IDLE;
            paddr    <= '0;
            pwrite   <= 1'b0;
            penable  <= 1'b0;
            pwdata   <= '0;
            sent_cnt <= '0;
            gap_cnt  <= '0;
`ifdef I2S_STREAM_TIMEOUT_EN
            poll_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !empty) begin
                        state   <= RD_SETUP;
                        paddr   <= ADR_OFFSET + STAT_OFS;
                        pwrite  <= 1'b0;
                        penable <= 1'b0;
`ifdef I2S_STREAM_TIMEOUT_EN
                        poll_cnt <= '0;
`endif
                    end
                end
                RD_SETUP: begin
                    penable <= 1'b1;
                    state   <= RD_ACCESS;
                end
                RD_ACCESS: begin
                    penable <= 1'b0;
                    if (prdata[TXRDY_BIT]) begin
                        // A write starts only while enabled. Otherwise the read pair ends here.
                        if (enable) begin
                            state  <= WR_SETUP;
                            paddr  <= ADR_OFFSET + TXD_OFS;
                            pwrite <= 1'b1;
                            pwdata <= mem[rd_ptr[AW-1:0]];
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
`ifdef I2S_STREAM_TIMEOUT_EN
                        if (drop) begin
                            timeout_q <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            poll_cnt <= poll_cnt + PW'(1);
                            gap_cnt  <= '0;
                            state    <= GAP;
                        end
`else
                        gap_cnt <= '0;
                        state   <= GAP;
`endif
                    end
                end
                GAP: begin
                    // paddr and pwrite still hold the status read, so the next poll reuses them.
                    if (gap_cnt == GW'(POLL_GAP - 1))
                        state <= enable ? RD_SETUP : IDLE;
                    else
                        gap_cnt <= gap_cnt + GW'(1);
                end
                WR_SETUP: begin
                    penable <= 1'b1;
                    state   <= WR_ACCESS;
                end
                WR_ACCESS: begin
                    penable  <= 1'b0;
                    pwrite   <= 1'b0;
                    sent_cnt <= sent_cnt + 16'd1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_apb_streamer.sv
// Directed bench for i2s_apb_streamer. It keeps a scoreboard of the expected
// APB write data, which is popped whenever a write access phase is seen.
`timescale 1ns/1ps
module tb_i2s_apb_streamer;
`ifdef I2S_STREAM_TIMEOUT_EN
    localparam int TB_MAX_POLLS = 3;
    localparam int NR_FAILS     = 2;
`else
    localparam int TB_MAX_POLLS = 255;
    localparam int NR_FAILS     = 3;
`endif

    logic        pclk = 1'b0;
    logic        preset = 1'b0;
    logic        enable = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic [31:0] paddr, pwdata, prdata;
    logic        pwrite, penable, busy, timeout;
    logic [15:0] sent_cnt;

    int          nchk = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          fails_left = 0;
    bit          never_rdy = 1'b0;
    bit          dec_pend = 1'b0;
    int          rd_cyc[$];
    int          wr_cyc[$];
    logic [31:0] sb[$];

    always #5 pclk = ~pclk;

    // Transceiver status model: only bit 12 signals ready, and the other bits are noise.
    always_comb prdata = (!never_rdy && fails_left == 0) ? 32'h0000_1000 : 32'hFFFF_EFFF;

    i2s_apb_streamer #(.MAX_POLLS(TB_MAX_POLLS)) dut (
        .pclk(pclk), .preset(preset), .enable(enable),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .paddr(paddr), .pwrite(pwrite), .penable(penable), .pwdata(pwdata),
        .prdata(prdata), .busy(busy), .sent_cnt(sent_cnt), .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, then observe any APB access phase.
    task automatic step();
        @(negedge pclk);
        cyc++;
        if (dec_pend) begin
            dec_pend = 1'b0;
            if (fails_left > 0) fails_left--;
        end
        if (penable && !pwrite) begin
            rd_cyc.push_back(cyc);
            chk("rd_addr", paddr, 32'h8);
            dec_pend = 1'b1;
        end
        if (penable && pwrite) begin
            wr_cyc.push_back(cyc);
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                chk("wr_data", pwdata, sb.pop_front());
                chk("wr_addr", paddr, 32'h4);
            end
        end
    endtask

    task automatic push(input logic [31:0] d);
        s_valid = 1'b1;
        s_data  = d;
        if (s_ready) sb.push_back(d);
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_sent(input string tag, input int target, input int bound);
        for (int i = 0; i < bound && sent_cnt != 16'(target); i++) step();
        chk(tag, 32'(sent_cnt), 32'(target));
    endtask

    initial begin
        int k, exp_sent, nrd;

        // Reset state
        step(); step();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sent", sent_cnt, 0);
        chk("rst_timeout", timeout, 0);
        preset = 1'b1;
        step();
        chk("rel_s_ready", s_ready, 1);

        // Single sample, transceiver always ready
        push(32'hA5A5_0001);
        k = cyc;
        step();
        chk("rds_addr", paddr, 32'h8);
        chk("rds_pwrite", pwrite, 0);
        chk("rds_penable", penable, 0);
        step(); step();
        chk("wrs_pwrite", pwrite, 1);
        chk("wrs_penable", penable, 0);
        chk("wrs_pwdata", pwdata, 32'hA5A5_0001);
        step();
        chk("wr_latency", 32'(wr_cyc[$] - k), 32'd4);
        step();
        chk("single_sent", sent_cnt, 1);
        chk("single_busy", busy, 0);
        exp_sent = 1;

        // Not ready for several polls
        rd_cyc.delete();
        fails_left = NR_FAILS;
        push(32'h1234_5678);
        exp_sent++;
        wait_sent("nr_sent", exp_sent, 80);
        chk("nr_reads", 32'(rd_cyc.size()), 32'(NR_FAILS + 1));
        for (int i = 1; i < rd_cyc.size(); i++)
            chk("nr_spacing", 32'(rd_cyc[i] - rd_cyc[i-1]), 32'd4);

        // Backpressure: the FIFO fills while the transceiver is busy
        never_rdy = 1'b1;
        wr_cyc.delete();
        for (int i = 0; i < 6; i++) push(32'hB000_0000 + 32'(i));
        chk("bp_accepted", 32'(sb.size()), 32'd4);
        chk("bp_s_ready", s_ready, 0);
        never_rdy = 1'b0;
        exp_sent += 4;
        wait_sent("bp_sent", exp_sent, 120);
        chk("bp_busy", busy, 0);
        chk("bp_writes", 32'(wr_cyc.size()), 32'd4);
        for (int i = 1; i < wr_cyc.size(); i++)
            chk("bp_spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd5);

        // Enable drops during WR_SETUP
        push(32'hC000_0001);
        step(); step(); step();
        chk("en_wrs", {penable, pwrite}, 2'b01);
        enable = 1'b0;
        step();
        chk("en_wra", {penable, pwrite}, 2'b11);
        step();
        exp_sent++;
        chk("en_sent", sent_cnt, 16'(exp_sent));
        nrd = rd_cyc.size();
        push(32'hC000_0002);
        for (int i = 0; i < 20; i++) step();
        chk("en_no_poll", 32'(rd_cyc.size()), 32'(nrd));
        chk("en_busy", busy, 1);
        chk("en_sent_hold", sent_cnt, 16'(exp_sent));
        enable = 1'b1;
        exp_sent++;
        wait_sent("en_resume", exp_sent, 40);

        // Poll timeout / endless polling
        never_rdy = 1'b1;
        rd_cyc.delete();
        push(32'hD000_0001);
`ifdef I2S_STREAM_TIMEOUT_EN
        void'(sb.pop_back());
        for (int i = 0; i < 60 && !timeout; i++) step();
        chk("to_flag", timeout, 1);
        chk("to_reads", 32'(rd_cyc.size()), 32'(TB_MAX_POLLS));
        chk("to_sent", sent_cnt, 16'(exp_sent));
        chk("to_busy", busy, 0);
        never_rdy = 1'b0;
`else
        for (int i = 0; i < 420; i++) step();
        chk("poll_100", 32'(rd_cyc.size() >= 100), 32'd1);
        chk("poll_timeout", timeout, 0);
        chk("poll_busy", busy, 1);
        never_rdy = 1'b0;
        exp_sent++;
        wait_sent("poll_sent", exp_sent, 40);
`endif

        // Reset during WR_SETUP abandons the write
        push(32'hE000_0001);
        step(); step(); step();
        chk("rm_wrs", pwrite, 1);
        preset = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("rm_penable", penable, 0);
        chk("rm_pwrite", pwrite, 0);
        chk("rm_paddr", paddr, 0);
        chk("rm_pwdata", pwdata, 0);
        chk("rm_busy", busy, 0);
        chk("rm_sent", sent_cnt, 0);
        chk("rm_timeout", timeout, 0);
        chk("rm_s_ready", s_ready, 0);
        step();
        preset = 1'b1;
        step();
        chk("rm_rel_ready", s_ready, 1);
        chk("rm_rel_busy", busy, 0);
        push(32'hF000_0001);
        wait_sent("rm_after_sent", 1, 40);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
